pix_stream_packer: RTL
======================

# pix_stream_packer

Parametrised pixel-to-byte packer between the CCD timing/ADC pixel output and the FT232H USB FIFO interface, running in the `clk_160M` domain. Generalises the current path, which sends only `pix_data[15:8]` with no framing. Adds:
- selectable 8-bit or full-width (two-byte) pixel modes;
- a per-line framing header carrying a line counter;
- an internal byte FIFO with valid/ready output;
- sticky overflow reporting with whole-pixel and whole-line drop rules.

## Interface
- `PIX_W`, 16, pixel width in bits, 9..16.
- `DEPTH`, 1024, FIFO depth in bytes, power of two, >= 8.
- `clk_160M`  in  1  sole clock; all logic rising-edge.
- `nrst`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  line acceptance enable, sampled at `line_start`.
- `mode`  in  1  0 = one byte/pixel, 1 = two bytes/pixel; sampled at `line_start`.
- `line_start`  in  1  one-cycle pulse before first pixel of a line.
- `pix_valid`  in  1  pixel strobe.
- `pix_data`  in  PIX_W  pixel sample.
- `out_data`  out  8  FIFO head byte.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid & out_ready`.
- `overflow`  out  1  sticky drop flag.
- `clr_ovf`  in  1  clears `overflow`.
- `line_cnt`  out  16  lines started since reset; wraps 0xFFFF -> 0.
- `fill`  out  $clog2(DEPTH)+1  bytes currently stored.

## Operation
- Aligned word `A = {pix_data, (16-PIX_W)'b0}`.
  - Mode 0 emits `A[15:8]`.
  - Mode 1 emits `A[15:8]`, then `A[7:0]`.
- Header, 4 bytes, in order: `0xA5`, `N[15:8]`, `N[7:0]`, `{7'b0, mode}`. N is the `line_cnt` value before increment.
- FSM states and transitions:
  - IDLE -> HDR on `line_start & en`.
  - HDR holds 4 cycles, one header byte written per cycle, then -> PIX.
  - PIX -> HDR on `line_start & en`.
  - PIX -> IDLE on `line_start & !en`.
- `line_start & en` always increments `line_cnt`, including on dropped lines, so the host sees numbering gaps.
- Line drop: if FIFO free space < 4 at `line_start` (with `en` = 1), no header is written and the state goes to DROP.
  - `overflow` is set.
  - Pixels in DROP are discarded without further flag updates.
  - DROP exits like PIX on the next `line_start`.
- Pixel accept condition: state PIX, free space >= bytes-per-pixel (1 or 2), and no pending second byte. Otherwise the whole pixel is dropped and `overflow` is set.
- `line_start & !en` in HDR is ignored. `line_start & en` in HDR is also ignored, and `line_cnt` is unchanged.
- `pix_valid` in IDLE is ignored silently. `pix_valid` in HDR is dropped and sets `overflow`.
- Free space counts bytes already stored plus bytes scheduled (header remainder, pending LSB).
- `overflow` set takes priority over `clr_ovf` in the same cycle.
- FIFO read and write in the same cycle are legal at any fill. Full with simultaneous read: scheduled writes proceed.

## Timing
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `overflow` = 0, `line_cnt` = 0, `fill` = 0.
  - FSM in IDLE, FIFO empty, pending byte cleared.
- Reset takes effect immediately on `nrst` low. Reset mid-line discards all FIFO contents.
- `line_start` at cycle 0 -> header bytes written cycles 1..4.
- Pixel at cycle p:
  - MSB written at p+1.
  - Mode 1 LSB written at p+2; any `pix_valid` at p+1 is dropped.
- Byte written at cycle w -> `out_valid` and `out_data` valid at w+1 (show-ahead, registered).
- `fill` updates the cycle after each write/read. `line_cnt` updates at cycle 1.
- Minimum legal pixel spacing: 1 cycle in mode 0, 2 cycles in mode 1. First pixel no earlier than cycle 5 after `line_start`.

## Test plan
- Mode 0 byte order: PIX_W=16, `out_ready`=1. `line_start`, then pixels 0xABCD, 0x1234, 0xFF00 at 2-cycle spacing from cycle 5 -> bytes A5 00 00 00 AB 12 FF, `line_cnt`=1, `overflow`=0.
- Mode 1 alignment: PIX_W=12, pixel 0xABC -> bytes AB C0 after header `A5 00 00 01`. Back-to-back pixels at p, p+1 -> second dropped, `overflow`=1.
- Backpressure fill: DEPTH=16, mode 1, `out_ready`=0, `line_start` + 8 pixels -> `fill`=16, pixels 7-8 dropped, `overflow`=1. Draining then yields exactly 16 bytes.
- Line drop: FIFO with 14/16 bytes at `line_start` -> no header, pixels discarded, `line_cnt` increments. After draining, the next line header carries N = previous+2.
- Flag rules:
  - `clr_ovf` coincident with a drop -> `overflow` stays 1.
  - `clr_ovf` alone -> 0 next cycle.
  - `line_start & !en` in PIX -> IDLE; subsequent pixels produce no bytes.
- Async reset: assert `nrst` mid-line with `out_valid`=1 -> all outputs 0 without a clock edge. After release, first header N=0.

Source files
------------

// File: rtl/pix_stream_packer.sv
// Packs CCD pixel samples into a framed byte stream (4-byte line header plus
// 1 or 2 bytes per pixel) buffered in a byte FIFO with valid/ready output.
module pix_stream_packer #(
  parameter int PIX_W = 16,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_160M,
  input  logic                     nrst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     line_start,
  input  logic                     pix_valid,
  input  logic [PIX_W-1:0]         pix_data,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [15:0]              line_cnt,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int UW = AW + 3;
  localparam logic [UW-1:0] CAP = UW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, PIX, DROP} state_t;

  state_t          state;
  logic [1:0]      hdr_idx;
  logic [15:0]     hdr_n;
  logic            mode_r;
  logic            vld_p1;
  logic            pend_p1;
  logic [7:0]      byte_p1;
  logic [7:0]      lsb_p1;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  logic [15:0]     aligned;
  logic [7:0]      hdr_byte;
  logic [7:0]      wdata;
  logic            hdr_we;
  logic            we;
  logic            rd;
  logic [FW-1:0]   fill_nx;
  logic [UW-1:0]   used;
  logic [UW-1:0]   need;
  logic            start_ln;
  logic            stop_ln;
  logic            room_hdr;
  logic            room_pix;
  logic            accept;
  logic            drop_pix;
  logic            set_ovf;

  always_comb begin
    aligned  = 16'(pix_data) << (16 - PIX_W);
    hdr_byte = 8'hA5;
    case (hdr_idx)
      2'd0:    hdr_byte = 8'hA5;
      2'd1:    hdr_byte = hdr_n[15:8];
      2'd2:    hdr_byte = hdr_n[7:0];
      default: hdr_byte = {7'b0, mode_r};
    endcase
    // An in-flight pixel byte owns the write port; the header just waits a cycle.
    hdr_we  = (state == HDR) && !vld_p1;
    we      = vld_p1 || hdr_we;
    wdata   = vld_p1 ? byte_p1 : hdr_byte;
    rd      = out_valid && out_ready;
    fill_nx = fill + FW'(we) - FW'(rd);
    // Occupancy includes every byte already promised but not yet in the FIFO.
    used    = UW'(fill) + UW'(vld_p1) + UW'(pend_p1)
            + ((state == HDR) ? UW'(3'd4 - 3'(hdr_idx)) : '0);
    need    = mode_r ? UW'(2) : UW'(1);
    room_pix = (used + need) <= CAP;
    accept   = pix_valid && (state == PIX) && room_pix && !pend_p1;
    drop_pix = pix_valid && (((state == PIX) && !accept) || (state == HDR));
    start_ln = line_start && en && (state != HDR);
    stop_ln  = line_start && !en && (state != HDR);
    room_hdr = (used + (accept ? need : '0) + UW'(4)) <= CAP;
    set_ovf  = drop_pix || (start_ln && !room_hdr);
  end

  // p0 -> p1: line control, pixel byte scheduling, FIFO pointers
  always_ff @(posedge clk_160M or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      hdr_idx   <= 2'd0;
      mode_r    <= 1'b0;
      vld_p1    <= 1'b0;
      pend_p1   <= 1'b0;
      line_cnt  <= 16'd0;
      overflow  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (start_ln) begin
        line_cnt <= line_cnt + 16'd1;
        mode_r   <= mode;
        hdr_idx  <= 2'd0;
        state    <= room_hdr ? HDR : DROP;
      end else if (stop_ln) begin
        state <= IDLE;
      end else if (hdr_we) begin
        hdr_idx <= hdr_idx + 2'd1;
        if (hdr_idx == 2'd3) state <= PIX;
      end
      vld_p1  <= accept || pend_p1;
      pend_p1 <= accept && mode_r;
      if (set_ovf)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (we) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      fill      <= fill_nx;
      out_valid <= (fill_nx != '0);
    end
  end

  always_ff @(posedge clk_160M) begin
    if (start_ln) hdr_n <= line_cnt;
    if (accept) begin
      byte_p1 <= aligned[15:8];
      lsb_p1  <= aligned[7:0];
    end else if (pend_p1) begin
      byte_p1 <= lsb_p1;
    end
    if (we) mem[wptr] <= wdata;
  end

  assign out_data = out_valid ? mem[rptr] : 8'h00;

endmodule
